// File: rtl/food_disp_pkg.sv
// Shared types and constants for the pet-food dispenser controller.
package food_disp_pkg;

  localparam int WEIGHT_W = 7;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_REFILL,
    ST_FEED,
    ST_WARN,
    ST_PLAY_DISPENSE,
    ST_PLAY_WAIT,
    ST_PLAY_FAIL
  } state_t;

  // Moore output bundle decoded from the current state.
  typedef struct packed {
    logic food_gate;
    logic warning;
    logic play_flag;
    logic fail_flag;
  } outs_t;

endpackage

// File: rtl/play_quota_counter.sv
// Daily play-treat counter: saturating increment, day-rollover clear, quota flag.
module play_quota_counter #(
  parameter int MAX_PLAYS = 3,
  parameter int CNT_W     = $clog2(MAX_PLAYS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             newday,
  output logic [CNT_W-1:0] play_count,
  output logic             quota_ok
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_PLAYS);

  // Count granted plays; a day rollover wins over a same-cycle increment.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      play_count <= '0;
    end else if (newday) begin
      play_count <= '0;
    end else if (inc && (play_count < MAX_VAL)) begin
      play_count <= play_count + 1'b1;
    end
  end

  assign quota_ok = (play_count < MAX_VAL);

endmodule

// File: rtl/food_dispenser_fsm.sv
// Automatic pet-food dispenser controller: scheduled meals, quota-limited play
// treats and refill lockout, with Moore outputs decoded from the state.
module food_dispenser_fsm
  import food_disp_pkg::*;
#(
  parameter int MAX_PLAYS    = 3,
  parameter int TREAT_WEIGHT = 1,
  parameter int PLAY_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                timesup,
  input  logic [WEIGHT_W-1:0] food_weight,
  input  logic [WEIGHT_W-1:0] set_food_weight,
  input  logic                refill_detector,
  input  logic                cap_detector,
  input  logic                play_function_pedal,
  input  logic                initialize_flag,
  input  logic                newday,
  output logic                food_gate,
  output logic                warning,
  output logic                play_function_flag,
  output logic                play_function_fail_flag
);

  localparam int CNT_W = $clog2(MAX_PLAYS + 1);
  localparam int TMR_W = $clog2(PLAY_TIMEOUT + 1);

  localparam logic [WEIGHT_W-1:0] TREAT_VAL   = WEIGHT_W'(TREAT_WEIGHT);
  localparam logic [TMR_W-1:0]    TIMEOUT_VAL = TMR_W'(PLAY_TIMEOUT);

  state_t              state;
  state_t              state_next;
  outs_t               outs;
  logic [WEIGHT_W-1:0] target;
  logic [TMR_W-1:0]    timer;
  logic                load_timer;
  logic                play_inc;
  logic [CNT_W-1:0]    play_count;
  logic                quota_ok;
  logic                bowl_empty;

  assign bowl_empty = (food_weight == '0);

  play_quota_counter #(
    .MAX_PLAYS (MAX_PLAYS),
    .CNT_W     (CNT_W)
  ) u_quota (
    .clk        (clk),
    .reset      (reset),
    .inc        (play_inc),
    .newday     (newday),
    .play_count (play_count),
    .quota_ok   (quota_ok)
  );

  // State register; reset forces INIT so every output drops at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Meal target captured when the user finishes configuration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target <= '0;
    end else if ((state == ST_INIT) && initialize_flag) begin
      target <= set_food_weight;
    end
  end

  // Cycles spent waiting for a treat to be eaten; holds 1 in the first wait cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (load_timer) begin
      timer <= TMR_W'(1);
    end else if ((state == ST_PLAY_WAIT) && (timer != TIMEOUT_VAL)) begin
      timer <= timer + 1'b1;
    end
  end

  // Next-state selection and Moore output decode.
  // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_next = state;
    load_timer = 1'b0;
    play_inc   = 1'b0;
    outs       = '0;
    unique case (state)
      ST_INIT: begin
        if (initialize_flag) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (refill_detector) begin
          state_next = ST_REFILL;
        end else if (timesup) begin
          state_next = bowl_empty ? ST_FEED : ST_WARN;
        end else if (play_function_pedal) begin
          if (quota_ok && bowl_empty) begin
            state_next = ST_PLAY_DISPENSE;
            play_inc   = 1'b1;
          end else begin
            state_next = ST_PLAY_FAIL;
          end
        end
      end
      ST_REFILL: begin
        if (!refill_detector && !cap_detector) state_next = ST_IDLE;
      end
      ST_FEED: begin
        outs.food_gate = 1'b1;
        if (food_weight >= target) state_next = ST_IDLE;
      end
      ST_WARN: begin
        outs.warning = 1'b1;
        if (bowl_empty) state_next = ST_IDLE;
      end
      ST_PLAY_DISPENSE: begin
        outs.food_gate = 1'b1;
        outs.play_flag = 1'b1;
        if (food_weight >= TREAT_VAL) begin
          state_next = ST_PLAY_WAIT;
          load_timer = 1'b1;
        end
      end
      ST_PLAY_WAIT: begin
        outs.play_flag = 1'b1;
        if (bowl_empty || (timer >= TIMEOUT_VAL)) state_next = ST_IDLE;
      end
      ST_PLAY_FAIL: begin
        outs.fail_flag = 1'b1;
        if (!play_function_pedal) state_next = ST_IDLE;
      end
      default: state_next = ST_INIT;
    endcase
  end

  assign food_gate               = outs.food_gate;
  assign warning                 = outs.warning;
  assign play_function_flag      = outs.play_flag;
  assign play_function_fail_flag = outs.fail_flag;

  // The quota counter must never run past its ceiling.
  a_count_bounded: assert property (@(posedge clk) disable iff (reset)
    play_count <= CNT_W'(MAX_PLAYS));

endmodule

// File: tb/tb_food_dispenser_fsm.sv
// Self-checking bench: behavioural model compared every cycle, plus directed literal checks.
module tb_food_dispenser_fsm;

  localparam int MAX_PLAYS    = 3;
  localparam int TREAT_WEIGHT = 1;
  localparam int PLAY_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       timesup = 1'b0;
  logic [6:0] food_weight = '0;
  logic [6:0] set_food_weight = '0;
  logic       refill_detector = 1'b0;
  logic       cap_detector = 1'b0;
  logic       play_function_pedal = 1'b0;
  logic       initialize_flag = 1'b0;
  logic       newday = 1'b0;
  logic       food_gate;
  logic       warning;
  logic       play_function_flag;
  logic       play_function_fail_flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  food_dispenser_fsm #(
    .MAX_PLAYS    (MAX_PLAYS),
    .TREAT_WEIGHT (TREAT_WEIGHT),
    .PLAY_TIMEOUT (PLAY_TIMEOUT)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .timesup                 (timesup),
    .food_weight             (food_weight),
    .set_food_weight         (set_food_weight),
    .refill_detector         (refill_detector),
    .cap_detector            (cap_detector),
    .play_function_pedal     (play_function_pedal),
    .initialize_flag         (initialize_flag),
    .newday                  (newday),
    .food_gate               (food_gate),
    .warning                 (warning),
    .play_function_flag      (play_function_flag),
    .play_function_fail_flag (play_function_fail_flag)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {
    M_SETUP, M_READY, M_HOPPER, M_MEAL, M_LEFTOVER, M_TREAT_OUT, M_TREAT_EATEN, M_REFUSED
  } mode_e;

  mode_e m_mode   = M_SETUP;
  int    m_target = 0;
  int    m_plays  = 0;
  int    m_waited = 0;

  task automatic model_step();
    int plays_after;
    if (reset) begin
      m_mode   = M_SETUP;
      m_target = 0;
      m_plays  = 0;
      m_waited = 0;
    end else begin
      plays_after = m_plays;
      case (m_mode)
        M_SETUP: if (initialize_flag) begin
          m_target = int'(set_food_weight);
          m_mode   = M_READY;
        end
        M_READY: begin
          if (refill_detector) m_mode = M_HOPPER;
          else if (timesup) m_mode = (food_weight == 0) ? M_MEAL : M_LEFTOVER;
          else if (play_function_pedal) begin
            if (m_plays < MAX_PLAYS && food_weight == 0) begin
              m_mode      = M_TREAT_OUT;
              plays_after = m_plays + 1;
            end else begin
              m_mode = M_REFUSED;
            end
          end
        end
        M_HOPPER:   if (!refill_detector && !cap_detector) m_mode = M_READY;
        M_MEAL:     if (int'(food_weight) >= m_target) m_mode = M_READY;
        M_LEFTOVER: if (food_weight == 0) m_mode = M_READY;
        M_TREAT_OUT: if (int'(food_weight) >= TREAT_WEIGHT) begin
          m_mode   = M_TREAT_EATEN;
          m_waited = 0;
        end
        M_TREAT_EATEN: begin
          m_waited++;
          if (food_weight == 0 || m_waited >= PLAY_TIMEOUT) m_mode = M_READY;
        end
        M_REFUSED:  if (!play_function_pedal) m_mode = M_READY;
        default:    m_mode = M_SETUP;
      endcase
      if (newday) plays_after = 0;
      m_plays = plays_after;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // Per-cycle comparison of all outputs against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("cyc_gate", food_gate, (m_mode == M_MEAL || m_mode == M_TREAT_OUT));
    check("cyc_warning", warning, (m_mode == M_LEFTOVER));
    check("cyc_play_flag", play_function_flag, (m_mode == M_TREAT_OUT || m_mode == M_TREAT_EATEN));
    check("cyc_fail_flag", play_function_fail_flag, (m_mode == M_REFUSED));
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_play();
    play_function_pedal = 1'b1;
    tick();
    check("play_gate_open", food_gate, 1'b1);
    check("play_flag_on", play_function_flag, 1'b1);
    play_function_pedal = 1'b0;
    food_weight = 7'd1;
    tick();
    check("play_gate_closed", food_gate, 1'b0);
    check("play_flag_held", play_function_flag, 1'b1);
    food_weight = 7'd0;
    tick();
    check("play_flag_off", play_function_flag, 1'b0);
  endtask

  initial begin
    int high;

    // Reset: all outputs low.
    tick(2);
    check("rst_gate", food_gate, 1'b0);
    check("rst_warning", warning, 1'b0);
    check("rst_play", play_function_flag, 1'b0);
    check("rst_fail", play_function_fail_flag, 1'b0);
    reset = 1'b0;

    // Initialise with target 35, then a meal on an empty bowl.
    set_food_weight = 7'd35;
    initialize_flag = 1'b1;
    tick();
    initialize_flag = 1'b0;
    timesup = 1'b1;
    tick();
    check("init_feed_gate", food_gate, 1'b1);
    timesup = 1'b0;
    food_weight = 7'd35;
    tick();
    check("init_feed_done", food_gate, 1'b0);
    food_weight = 7'd0;

    // Refill lockout; cap must also be back on before leaving.
    refill_detector = 1'b1;
    tick();
    cap_detector = 1'b1;
    refill_detector = 1'b0;
    tick();
    timesup = 1'b1;
    tick();
    check("refill_timesup_ignored", food_gate, 1'b0);
    timesup = 1'b0;
    cap_detector = 1'b0;
    tick();

    // Meal fill: gate holds below target, drops one cycle after reaching it.
    timesup = 1'b1;
    tick();
    check("meal_gate_open", food_gate, 1'b1);
    timesup = 1'b0;
    food_weight = 7'd12;
    tick();
    check("meal_gate_partial", food_gate, 1'b1);
    food_weight = 7'd35;
    tick();
    check("meal_gate_closed", food_gate, 1'b0);

    // Leftover warning.
    food_weight = 7'd12;
    timesup = 1'b1;
    tick();
    check("warn_on", warning, 1'b1);
    check("warn_gate_closed", food_gate, 1'b0);
    timesup = 1'b0;
    food_weight = 7'd35;
    tick();
    check("warn_still_on", warning, 1'b1);
    food_weight = 7'd0;
    tick();
    check("warn_cleared", warning, 1'b0);
    timesup = 1'b1;
    tick();
    check("warn_then_feed", food_gate, 1'b1);
    timesup = 1'b0;
    food_weight = 7'd35;
    tick();
    check("warn_feed_done", food_gate, 1'b0);
    food_weight = 7'd0;
    tick();

    // First play with the pedal held two cycles.
    play_function_pedal = 1'b1;
    tick();
    check("p1_gate", food_gate, 1'b1);
    tick();
    check("p1_gate_hold", food_gate, 1'b1);
    check("p1_flag", play_function_flag, 1'b1);
    play_function_pedal = 1'b0;
    food_weight = 7'd1;
    tick();
    check("p1_gate_closed", food_gate, 1'b0);
    check("p1_flag_held", play_function_flag, 1'b1);
    food_weight = 7'd0;
    tick();
    check("p1_flag_off", play_function_flag, 1'b0);

    // Plays two and three, then the quota refuses the fourth.
    do_play();
    do_play();
    play_function_pedal = 1'b1;
    tick();
    check("quota_fail", play_function_fail_flag, 1'b1);
    check("quota_no_gate", food_gate, 1'b0);
    tick(3);
    check("quota_fail_held", play_function_fail_flag, 1'b1);
    play_function_pedal = 1'b0;
    tick();
    check("quota_fail_released", play_function_fail_flag, 1'b0);

    // Day rollover restores the quota (play count becomes 1).
    newday = 1'b1;
    tick();
    newday = 1'b0;
    do_play();

    // Non-empty bowl refuses a long press without consuming quota.
    food_weight = 7'd1;
    play_function_pedal = 1'b1;
    tick(90);
    check("bowl_fail_held", play_function_fail_flag, 1'b1);
    play_function_pedal = 1'b0;
    tick();
    check("bowl_fail_released", play_function_fail_flag, 1'b0);
    food_weight = 7'd0;

    // Uneaten treat: flag stays up for exactly the timeout (play count becomes 2).
    play_function_pedal = 1'b1;
    tick();
    play_function_pedal = 1'b0;
    food_weight = 7'd1;
    tick();
    high = 0;
    for (int i = 0; i < 200 && play_function_flag; i++) begin
      high++;
      tick();
    end
    check("timeout_cycles", high, PLAY_TIMEOUT);
    food_weight = 7'd0;
    tick();

    // Third play succeeds, fourth fails: the refused long press did not count.
    do_play();
    play_function_pedal = 1'b1;
    tick();
    check("quota_after_newday", play_function_fail_flag, 1'b1);
    play_function_pedal = 1'b0;
    tick();

    // Asynchronous reset mid-meal closes the gate before any clock edge.
    timesup = 1'b1;
    tick();
    check("pre_reset_gate", food_gate, 1'b1);
    timesup = 1'b0;
    #2 reset = 1'b1;
    #1 check("async_reset_gate", food_gate, 1'b0);
    tick(2);
    reset = 1'b0;
    timesup = 1'b1;
    tick();
    check("needs_reinit", food_gate, 1'b0);
    timesup = 1'b0;

    // Re-initialise with target 0: FEED exits after a single cycle.
    set_food_weight = 7'd0;
    initialize_flag = 1'b1;
    tick();
    initialize_flag = 1'b0;
    timesup = 1'b1;
    tick();
    check("zero_target_gate", food_gate, 1'b1);
    timesup = 1'b0;
    tick();
    check("zero_target_exit", food_gate, 1'b0);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
